instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Requester side of the instruction-memory read interface. Holds the fetch PC and
//   drives Address. Waits a fixed settle time for the combinational InstructionMemory
//   read, then samples Data. Buffers {PC, instruction} pairs in a small queue and hands
//   them to decode over a valid/ready handshake. Branch redirects flush the queue.
// PARAMETERS
//   WAIT_CYCLES  2      cycles Address is held stable before Data is sampled (0 = sample same cycle)
//   QDEPTH       2      fetch queue entries (power of 2, >=2)
//   RESET_PC     64'h0  fetch PC loaded on reset
// PORTS
//   CLK         in   1   clock; all state updates on rising edge
//   Reset_L     in   1   asynchronous, active-low reset
//   Address     out  64  instruction memory address (= fetch PC)
//   Data        in   32  instruction memory read data
//   InstrValid  out  1   queue head valid
//   InstrReady  in   1   decode accepts head; pop when InstrValid & InstrReady
//   Instr       out  32  head instruction
//   InstrPC     out  64  head PC
//   Redirect    in   1   load RedirectPC, flush queue
//   RedirectPC  in   64  redirect target
//   Fault       out  1   alignment fault (IFU_ALIGN_CHECK_EN only; tied 0 otherwise)
// BEHAVIOUR
//   Reset (async, Reset_L=0):
//     - fetch_pc=RESET_PC, Address=RESET_PC; queue empty; InstrValid=0.
//     - Instr=0, InstrPC=0, Fault=0; cnt=WAIT_CYCLES; state=WAIT.
//   States:
//     WAIT  - cnt!=0: cnt--.
//           - cnt==0 with space (not full, or pop this cycle): push {fetch_pc, Data},
//             fetch_pc+=4, cnt=WAIT_CYCLES.
//           - cnt==0, full, no pop: go to HOLD.
//     HOLD  - queue full; Address stable; push on first cycle space exists, then WAIT.
//     FAULT - IFU_ALIGN_CHECK_EN only.
//   Throughput: one fetch per WAIT_CYCLES+1 cycles. First InstrValid is WAIT_CYCLES+1
//     rising edges after reset release.
//   Queue:
//     - Registered outputs; Instr/InstrPC reflect head, held stable while InstrValid & !InstrReady.
//     - Push and pop in the same cycle are both honoured, including when full.
//     - Pop when empty is ignored.
//   Redirect (highest priority, synchronous):
//     - Queue flushed; InstrValid=0 next cycle; a same-cycle pop is discarded.
//     - fetch_pc=RedirectPC, cnt=WAIT_CYCLES, state=WAIT.
//     - The in-flight sample is dropped.
//   Arithmetic:
//     - fetch_pc+4 is 64-bit and wraps modulo 2^64.
//     - Data is captured verbatim, including X from unmapped addresses.
//   Reset mid-operation: immediate return to reset values; no partial entry survives.
// CONFIGURATION
//   IFU_ALIGN_CHECK_EN defined:
//     - Redirect with RedirectPC[1:0]!=0 flushes the queue and enters FAULT.
//     - In FAULT: Fault=1, no fetches, InstrValid=0, Address holds RedirectPC.
//     - Exit FAULT via reset, or an aligned Redirect (Fault=0 next cycle, resume WAIT).
//   Not defined:
//     - RedirectPC[1:0] forced to 2'b00; Fault tied 0; FAULT state absent.
// TESTING
//   1. Reset, WAIT_CYCLES=2, InstrReady=1 -> InstrPC=0x0/Instr=F84003E9, then
//      0x4/F84083EA, then 0x8/F84103EB, one every 3 cycles.
//   2. InstrReady=0 after reset -> 2 entries (PC 0x0, 0x4); state HOLD; Address=0x8;
//      Instr=F84003E9 stable. Raise InstrReady -> pops in order, fetch resumes.
//   3. Queue full, InstrReady=1 in the cycle cnt==0 -> push and pop same edge; occupancy stays 2;
//      next head PC=0x4.
//   4. Redirect=1, RedirectPC=0x20 with InstrValid=1 and InstrReady=1 -> next cycle InstrValid=0,
//      pop discarded; then InstrPC=0x20/Instr=8B0901AD, then 0x24/CB09018C.
//   5. Reset_L pulsed low mid-WAIT at fetch_pc=0x14 -> Address=0x0 and InstrValid=0 immediately;
//      first instruction after release is F84003E9.
//   6. IFU_ALIGN_CHECK_EN, RedirectPC=0x22 -> Fault=1, no InstrValid for 10 cycles;
//      RedirectPC=0x34 -> Fault=0, then Instr=8A1F03E9.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port, decode handshake and redirect/fault signals
// shared by the fetch unit (master) and its environment (slave).
interface instruction_fetch_unit_if;
    logic [63:0] Address;
    logic [31:0] Data;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        Fault;

    modport master (
        output Address,
        input  Data,
        output InstrValid,
        input  InstrReady,
        output Instr,
        output InstrPC,
        input  Redirect,
        input  RedirectPC,
        output Fault
    );

    modport slave (
        input  Address,
        output Data,
        input  InstrValid,
        output InstrReady,
        input  Instr,
        input  InstrPC,
        output Redirect,
        output RedirectPC,
        input  Fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch PC / settle-timer FSM feeding a small {PC, instruction} queue to decode.
// Optional alignment fault checking on redirects is enabled by IFU_ALIGN_CHECK_EN.
module instruction_fetch_unit #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned QDEPTH      = 2,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input logic                        CLK,
    input logic                        Reset_L,
    instruction_fetch_unit_if.master   ifu
);

    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned NW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(WAIT_CYCLES);
    localparam logic [NW-1:0] NFULL      = NW'(QDEPTH);

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_WAIT, S_HOLD, S_FAULT} state_t;
`else
    typedef enum logic {S_WAIT, S_HOLD} state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0]   fetch_pc, fetch_pc_n;
    logic [NW-1:0] count;
    logic [NW-1:0] wr_idx;
    logic [63:0]   q_pc  [QDEPTH];
    logic [31:0]   q_ins [QDEPTH];
    logic          push, pop, flush, space;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= S_WAIT;
            cnt      <= CNT_RELOAD;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        fetch_pc_n = fetch_pc;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = (count != '0) && ifu.InstrReady;
        space      = (count != NFULL) || pop;
        if (ifu.Redirect) begin
            // Redirect outranks everything: the in-flight sample and any pop are dropped.
            flush   = 1'b1;
            pop     = 1'b0;
            cnt_n   = CNT_RELOAD;
            state_n = S_WAIT;
`ifdef IFU_ALIGN_CHECK_EN
            fetch_pc_n = ifu.RedirectPC;
            if (ifu.RedirectPC[1:0] != 2'b00)
                state_n = S_FAULT;
`else
            fetch_pc_n = ifu.RedirectPC & ~64'h3;
`endif
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CW'(1);
                    end else if (space) begin
                        push       = 1'b1;
                        fetch_pc_n = fetch_pc + 64'd4;
                        cnt_n      = CNT_RELOAD;
                    end else begin
                        state_n = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (space) begin
                        push       = 1'b1;
                        fetch_pc_n = fetch_pc + 64'd4;
                        cnt_n      = CNT_RELOAD;
                        state_n    = S_WAIT;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    assign wr_idx = count - NW'(pop);

    // Shift-register queue: entry 0 is always the head, so outputs come straight from flops.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            count <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_pc[i]  <= '0;
                q_ins[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + NW'(push) - NW'(pop);
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                if (push && (wr_idx == NW'(i))) begin
                    q_pc[i]  <= fetch_pc;
                    q_ins[i] <= ifu.Data;
                end else if (pop && (i + 1 < QDEPTH)) begin
                    q_pc[i]  <= q_pc[(i + 1) % QDEPTH];
                    q_ins[i] <= q_ins[(i + 1) % QDEPTH];
                end
            end
        end
    end

    assign ifu.Address    = fetch_pc;
    assign ifu.InstrValid = (count != '0);
    assign ifu.Instr      = q_ins[0];
    assign ifu.InstrPC    = q_pc[0];
`ifdef IFU_ALIGN_CHECK_EN
    assign ifu.Fault      = (state == S_FAULT);
`else
    assign ifu.Fault      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle-vector table for streaming
// and redirect, plus hand sequences for back-pressure, async reset, alignment and wrap.
module tb_instruction_fetch_unit;

    logic CLK;
    logic Reset_L;
    int   passed = 0;
    int   total  = 0;

    instruction_fetch_unit_if bif ();

    instruction_fetch_unit #(
        .WAIT_CYCLES(2),
        .QDEPTH(2),
        .RESET_PC(64'h0)
    ) dut (
        .CLK(CLK),
        .Reset_L(Reset_L),
        .ifu(bif)
    );

    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'h00: imem = 32'hF84003E9;
            64'h04: imem = 32'hF84083EA;
            64'h08: imem = 32'hF84103EB;
            64'h0C: imem = 32'hF84183EC;
            64'h10: imem = 32'hD65F03C0;
            64'h20: imem = 32'h8B0901AD;
            64'h24: imem = 32'hCB09018C;
            64'h34: imem = 32'h8A1F03E9;
            default: imem = 32'hA5000000 | {8'h00, a[23:0]};
        endcase
    endfunction

    assign bif.Data = imem(bif.Address);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic cyc(input bit rdy, input bit rd, input logic [63:0] rpc);
        bif.InstrReady = rdy;
        bif.Redirect   = rd;
        bif.RedirectPC = rpc;
        @(posedge CLK);
        #1;
    endtask

    task automatic head(input string name, input logic [63:0] pc, input logic [31:0] ins);
        chk({name, "_valid"}, {63'd0, bif.InstrValid}, 64'd1);
        chk({name, "_pc"}, bif.InstrPC, pc);
        chk({name, "_instr"}, {32'd0, bif.Instr}, {32'd0, ins});
    endtask

    task automatic do_reset();
        Reset_L        = 1'b0;
        bif.InstrReady = 1'b0;
        bif.Redirect   = 1'b0;
        bif.RedirectPC = '0;
        #2;
        chk("rst_addr", bif.Address, 64'h0);
        chk("rst_valid", {63'd0, bif.InstrValid}, 64'd0);
        chk("rst_instr", {32'd0, bif.Instr}, 64'd0);
        chk("rst_pc", bif.InstrPC, 64'h0);
        chk("rst_fault", {63'd0, bif.Fault}, 64'd0);
        @(negedge CLK);
        Reset_L = 1'b1;
    endtask

    typedef struct {
        bit          rdy;
        bit          rd;
        logic [63:0] rpc;
        bit          ev;
        logic [31:0] ei;
        logic [63:0] ep;
        logic [63:0] ea;
    } vec_t;

    vec_t vecs[16];

    initial begin
        Reset_L = 1'b0;

        // Streaming with InstrReady=1, then a redirect to 0x20 while a head is being popped.
        vecs[0]  = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h0};
        vecs[1]  = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h0};
        vecs[2]  = '{1'b1, 1'b0, 64'h0,  1'b1, 32'hF84003E9, 64'h0,  64'h4};
        vecs[3]  = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h4};
        vecs[4]  = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h4};
        vecs[5]  = '{1'b1, 1'b0, 64'h0,  1'b1, 32'hF84083EA, 64'h4,  64'h8};
        vecs[6]  = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h8};
        vecs[7]  = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h8};
        vecs[8]  = '{1'b1, 1'b0, 64'h0,  1'b1, 32'hF84103EB, 64'h8,  64'hC};
        vecs[9]  = '{1'b1, 1'b1, 64'h20, 1'b0, 32'h0,        64'h0,  64'h20};
        vecs[10] = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h20};
        vecs[11] = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h20};
        vecs[12] = '{1'b1, 1'b0, 64'h0,  1'b1, 32'h8B0901AD, 64'h20, 64'h24};
        vecs[13] = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h24};
        vecs[14] = '{1'b1, 1'b0, 64'h0,  1'b0, 32'h0,        64'h0,  64'h24};
        vecs[15] = '{1'b1, 1'b0, 64'h0,  1'b1, 32'hCB09018C, 64'h24, 64'h28};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
            chk($sformatf("vec%0d_valid", i), {63'd0, bif.InstrValid}, {63'd0, vecs[i].ev});
            chk($sformatf("vec%0d_addr", i), bif.Address, vecs[i].ea);
            chk($sformatf("vec%0d_fault", i), {63'd0, bif.Fault}, 64'd0);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_pc", i), bif.InstrPC, vecs[i].ep);
                chk($sformatf("vec%0d_instr", i), {32'd0, bif.Instr}, {32'd0, vecs[i].ei});
            end
        end

        // Back-pressure: fill, HOLD, release, full push+pop in WAIT.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, '0);
            head("hold", 64'h0, 32'hF84003E9);
            chk("hold_addr", bif.Address, 64'h8);
        end
        cyc(1'b1, 1'b0, '0);
        head("hold_release", 64'h4, 32'hF84083EA);
        chk("hold_release_addr", bif.Address, 64'hC);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        head("full_pushpop", 64'h8, 32'hF84103EB);
        chk("full_pushpop_addr", bif.Address, 64'h10);
        cyc(1'b0, 1'b0, '0);
        head("stall_stable", 64'h8, 32'hF84103EB);
        cyc(1'b1, 1'b0, '0);
        head("second_entry", 64'hC, 32'hF84183EC);
        cyc(1'b1, 1'b0, '0);
        head("single_pushpop", 64'h10, 32'hD65F03C0);
        chk("single_pushpop_addr", bif.Address, 64'h14);

        // Asynchronous reset in the middle of a WAIT count at fetch_pc 0x14.
        cyc(1'b0, 1'b0, '0);
        #2;
        Reset_L = 1'b0;
        #1;
        chk("async_rst_addr", bif.Address, 64'h0);
        chk("async_rst_valid", {63'd0, bif.InstrValid}, 64'd0);
        chk("async_rst_pc", bif.InstrPC, 64'h0);
        @(negedge CLK);
        Reset_L = 1'b1;
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        chk("post_rst_early_valid", {63'd0, bif.InstrValid}, 64'd0);
        cyc(1'b1, 1'b0, '0);
        head("post_rst_first", 64'h0, 32'hF84003E9);

        // Misaligned redirect target.
        do_reset();
`ifdef IFU_ALIGN_CHECK_EN
        cyc(1'b1, 1'b1, 64'h22);
        chk("fault_set", {63'd0, bif.Fault}, 64'd1);
        chk("fault_addr", bif.Address, 64'h22);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, '0);
            chk($sformatf("fault_hold%0d_valid", i), {63'd0, bif.InstrValid}, 64'd0);
            chk($sformatf("fault_hold%0d_fault", i), {63'd0, bif.Fault}, 64'd1);
        end
        chk("fault_hold_addr", bif.Address, 64'h22);
        cyc(1'b1, 1'b1, 64'h34);
        chk("fault_clear", {63'd0, bif.Fault}, 64'd0);
        chk("fault_clear_addr", bif.Address, 64'h34);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        head("fault_resume", 64'h34, 32'h8A1F03E9);
`else
        cyc(1'b1, 1'b1, 64'h22);
        chk("misalign_addr", bif.Address, 64'h20);
        chk("misalign_fault", {63'd0, bif.Fault}, 64'd0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        head("misalign_fetch", 64'h20, 32'h8B0901AD);
`endif

        // 64-bit wrap of fetch_pc.
        do_reset();
        cyc(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_redirect_addr", bif.Address, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        head("wrap_last", 64'hFFFF_FFFF_FFFF_FFFC, 32'hA5FFFFFC);
        chk("wrap_addr", bif.Address, 64'h0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        head("wrap_first", 64'h0, 32'hF84003E9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
